alu_pipe_hs: RTL and testbench
==============================

Name: alu_pipe_hs

Overview:
- Next-generation ALU for the datapath: parametrised width, registered result, and a valid/ready handshake on both sides.
- Keeps the existing 4-bit opcode encodings for ADD/SUB/AND/OR and adds XOR, shifts, set-less-than and an optional iterative multiplier.
- Sits between the register-read stage and writeback. Upstream stalls on in_ready; downstream backpressures with out_ready.

Parameters:
- WIDTH, 32, operand and result width (must be ≥4 and a power of two).
- SHAMT_W (localparam), $clog2(WIDTH), shift-amount width taken from B.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_ctrl  input  4  opcode.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- carry  output  1  ADD: carry-out; SUB: no-borrow (a ≥ b unsigned); all other ops: 0.
- overflow  output  1  signed overflow for ADD/SUB; all other ops: 0.
- illegal  output  1  opcode unsupported (result forced to 0).

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA (shift amount = b[SHAMT_W-1:0]).
  - 1000 SLT (signed), 1001 SLTU; both return 1 or 0 zero-extended.
  - 1010 MUL: low WIDTH bits of a*b, unsigned/signed identical.
  - All other opcodes: illegal.
- States: IDLE, BUSY, DONE.
- Reset (async, rst_n=0): state=IDLE; out_valid=0; result=0; zero=0; carry=0; overflow=0; illegal=0; mul counter=0. Reset mid-BUSY aborts the multiply; no output is produced.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- An operation is accepted on a rising edge where in_valid & in_ready.
- Single-cycle ops and illegal opcodes: accepted at edge k → DONE at edge k; result and flags are registered at k, and out_valid=1 after k.
- MUL: accepted at edge k → BUSY. The counter loads WIDTH; one shift-add step runs per edge. On the edge where the counter reaches 0, the result is registered and state goes to DONE. out_valid therefore rises after edge k+WIDTH.
- in_ready=0 throughout BUSY.
- DONE: result and flags are held stable while out_valid & !out_ready.
  - out_ready=1 with no new accept: go to IDLE; out_valid falls.
  - out_ready=1 together with in_valid: the new op is accepted on the same edge. Single-cycle op → stays in DONE with the new result (back-to-back, throughput 1/cycle). MUL → BUSY, out_valid=0.
- Flags:
  - zero is computed from the final registered result, including for MUL and illegal opcodes (illegal → zero=1).
  - ADD: carry/overflow from the (WIDTH+1)-bit sum.
  - SUB: a + ~b + 1; carry = bit WIDTH of that sum; overflow = (a[msb]≠b[msb]) & (res[msb]≠a[msb]).
- Shifts with shift amount 0 return a unchanged. SRA replicates a[msb].
- Wrap-around: ADD/SUB/MUL results are truncated mod 2^WIDTH.
- Inputs are sampled only on the accept edge. Changes to a, b or alu_ctrl during BUSY or DONE have no effect.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: opcode 1010 runs the iterative multiplier as above; the BUSY state and counter exist.
- Undefined: 1010 is illegal (single-cycle, result=0, illegal=1, zero=1); no multiplier logic and no BUSY state are synthesised.

Decomposition:
- Package alu_pkg: opcode localparams (OP_AND … OP_MUL), state enum (IDLE/BUSY/DONE), flag struct {zero, carry, overflow, illegal}.
- Sub-module alu_mul_iter: shift-add multiplier.
  - Interface: start, a, b, busy, done, product.
  - Instantiated only under ALU_MUL_EN.

Test Plan:
- Reset with rst_n=0 asserted mid-cycle → all outputs 0 immediately; in_ready=1 after release.
- ADD 0xFFFFFFFF+1 (WIDTH=32) → result=0, zero=1, carry=1, overflow=0. SUB 0x80000000-1 → result=0x7FFFFFFF, overflow=1, carry=1.
- SRA a=0x80000000, b=4 → 0xF8000000. SLT a=-1, b=1 → 1. SLTU a=-1, b=1 → 0.
- Back-to-back single-cycle ops with out_ready held 1 → one result per cycle, in order. Drop out_ready for 3 cycles → result held stable, in_ready=0.
- MUL 7*6 (ALU_MUL_EN defined) → out_valid exactly 32 cycles after accept, result=42, in_ready=0 during BUSY. Reset at BUSY cycle 10 → no out_valid.
- Opcode 1111, and 1010 with ALU_MUL_EN undefined → result=0, illegal=1, zero=1, one-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, handshake states and flag bundle for alu_pipe_hs
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic illegal;
  } flags_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per clock, low WIDTH bits kept
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, mc, mp;
  assign busy = cnt != '0;
  assign done = cnt == CW'(1);
  // product is the accumulator after this cycle's step, valid to capture when done
  assign product = acc + (mp[0] ? mc : '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      mc  <= '0;
      mp  <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      acc <= '0;
      mc  <= a;
      mp  <= b;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      acc <= product;
      mc  <= mc << 1;
      mp  <= mp >> 1;
    end
endmodule

// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: registered ALU with valid/ready handshake on both sides
// ALU_MUL_EN adds the iterative multiplier on opcode 1010; otherwise 1010 is illegal.
module alu_pipe_hs
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);
  localparam int SHAMT_W = $clog2(WIDTH);
  state_t state, state_n;
  flags_t fl, fl_c;
  logic [WIDTH-1:0] res_c, mul_p;
  logic [WIDTH:0] add_s, sub_s;
  logic [SHAMT_W-1:0] sh;
  logic accept, is_mul, mul_busy, mul_done;
`ifdef ALU_MUL_EN
  assign is_mul = alu_ctrl == OP_MUL;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(accept & is_mul), .a(a), .b(b),
    .busy(mul_busy), .done(mul_done), .product(mul_p)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_p    = '0;
`endif
  assign sh        = b[SHAMT_W-1:0];
  assign add_s     = {1'b0, a} + {1'b0, b};
  assign sub_s     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign in_ready  = (state == IDLE & !mul_busy) | (state == DONE & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = state == DONE;
  assign {zero, carry, overflow, illegal} = fl;
  always_comb begin
    res_c = '0;
    fl_c  = '0;
    case (alu_ctrl)
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_SLL:  res_c = a << sh;
      OP_SRL:  res_c = a >> sh;
      OP_SRA:  res_c = $signed(a) >>> sh;
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, a < b};
      OP_ADD: begin
        res_c         = add_s[WIDTH-1:0];
        fl_c.carry    = add_s[WIDTH];
        fl_c.overflow = (a[WIDTH-1] == b[WIDTH-1]) & (res_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c         = sub_s[WIDTH-1:0];
        fl_c.carry    = sub_s[WIDTH];
        fl_c.overflow = (a[WIDTH-1] != b[WIDTH-1]) & (res_c[WIDTH-1] != a[WIDTH-1]);
      end
      default: fl_c.illegal = 1'b1;
    endcase
    fl_c.zero = res_c == '0;
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = is_mul ? BUSY : DONE;
    else if (state == BUSY & mul_done) state_n = DONE;
    else if (state == DONE & out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      fl     <= '0;
    end else begin
      state <= state_n;
      if (accept & !is_mul) begin
        result <= res_c;
        fl     <= fl_c;
      end else if (state == BUSY & mul_done) begin
        result <= mul_p;
        fl     <= '{mul_p == '0, 1'b0, 1'b0, 1'b0};
      end
    end
endmodule

// File: tb/tb_alu_pipe_hs.sv
// tb_alu_pipe_hs: directed self-checking bench for alu_pipe_hs (WIDTH=32)
module tb_alu_pipe_hs;
  import alu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0] alu_ctrl = '0;
  logic in_ready, out_valid, zero, carry, overflow, illegal;
  logic [31:0] result;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;
  vec_t vecs [19] = '{
    '{OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        4'b1100},
    '{OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0110},
    '{OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0010},
    '{OP_SUB,  32'h5,        32'h7,        32'hFFFFFFFE, 4'b0000},
    '{OP_SUB,  32'h7,        32'h7,        32'h0,        4'b1100},
    '{OP_AND,  32'hF0F0,     32'hFF00,     32'hF000,     4'b0000},
    '{OP_OR,   32'hF0F0,     32'hFF00,     32'hFFF0,     4'b0000},
    '{OP_XOR,  32'hF0F0,     32'hFF00,     32'h0FF0,     4'b0000},
    '{OP_SLL,  32'h1,        32'd31,       32'h80000000, 4'b0000},
    '{OP_SLL,  32'h1,        32'h21,       32'h2,        4'b0000},
    '{OP_SRL,  32'h80000000, 32'd4,        32'h08000000, 4'b0000},
    '{OP_SRA,  32'h80000000, 32'd4,        32'hF8000000, 4'b0000},
    '{OP_SRA,  32'h80000001, 32'd0,        32'h80000001, 4'b0000},
    '{OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000},
    '{OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1000},
    '{OP_SLT,  32'h1,        32'hFFFFFFFF, 32'h0,        4'b1000},
    '{OP_SLTU, 32'h1,        32'hFFFFFFFF, 32'h1,        4'b0000},
    '{4'hF,    32'h1234,     32'h5678,     32'h0,        4'b1001},
    '{4'hB,    32'hFFFFFFFF, 32'h1,        32'h0,        4'b1001}
  };

  alu_pipe_hs #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    alu_ctrl = op;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, result, zero, carry, overflow, illegal} !== 37'h0) begin
      errors++;
      $display("FAIL reset_init out=%h want 0", {out_valid, result, zero, carry, overflow, illegal});
    end
    rst_n = 1'b1;
    issue(OP_ADD, 32'hFFFFFFFF, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, zero, carry, overflow, illegal} !== 37'h0) begin
      errors++;
      $display("FAIL reset_async out=%h want 0", {out_valid, result, zero, carry, overflow, illegal});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_ops;
    for (int i = 0; i < 19; i++) begin
      issue(vecs[i].op, vecs[i].x, vecs[i].y);
      checks++;
      if ({out_valid, result, zero, carry, overflow, illegal} !== {1'b1, vecs[i].r, vecs[i].f}) begin
        errors++;
        $display("FAIL op_%0d v/res/flags got %b/%h/%b want 1/%h/%b", i, out_valid, result,
                 {zero, carry, overflow, illegal}, vecs[i].r, vecs[i].f);
      end
    end
  endtask

  task automatic test_illegal_mul_op;
`ifndef ALU_MUL_EN
    issue(OP_MUL, 32'h7, 32'h6);
    checks++;
    if ({out_valid, result, zero, carry, overflow, illegal} !== {1'b1, 32'h0, 4'b1001}) begin
      errors++;
      $display("FAIL mul_illegal v/res/flags got %b/%h/%b want 1/0/1001", out_valid, result,
               {zero, carry, overflow, illegal});
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [3:0]  op [3] = '{OP_ADD, OP_SUB, OP_XOR};
    logic [31:0] x  [3] = '{32'd1, 32'd10, 32'hF};
    logic [31:0] y  [3] = '{32'd2, 32'd4, 32'h3};
    logic [31:0] r  [3] = '{32'd3, 32'd6, 32'hC};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_ctrl = op[i];
      a = x[i];
      b = y[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || result !== r[i]) begin
        errors++;
        $display("FAIL b2b_%0d v/res got %b/%h want 1/%h", i, out_valid, result, r[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    issue(OP_ADD, 32'd2, 32'd2);
    alu_ctrl = OP_ADD;
    a = 32'd9;
    b = 32'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, result} !== {2'b10, 32'd4}) begin
        errors++;
        $display("FAIL hold_%0d v/rdy/res got %b/%b/%h want 1/0/4", i, out_valid, in_ready, result);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd18) begin
      errors++;
      $display("FAIL release_res v/res got %b/%h want 1/12", out_valid, result);
    end
  endtask

  task automatic test_mul;
`ifdef ALU_MUL_EN
    int bad;
    issue(OP_MUL, 32'd7, 32'd6);
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_busy bad_cycles got %0d want 0", bad);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, result, zero, carry, overflow, illegal} !== {1'b1, 32'd42, 4'b0000}) begin
      errors++;
      $display("FAIL mul_7x6 v/res/flags got %b/%h/%b want 1/2a/0000", out_valid, result,
               {zero, carry, overflow, illegal});
    end
    issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (32) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h1) begin
      errors++;
      $display("FAIL mul_wrap v/res got %b/%h want 1/1", out_valid, result);
    end
    issue(OP_MUL, 32'd3, 32'd3);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_abort valid_cycles/rdy got %0d/%b want 0/1", bad, in_ready);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ops();
    test_illegal_mul_op();
    test_back_to_back();
    test_backpressure();
    test_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
